// File: rtl/qr_pkg.sv
// Shared constants and types for the QR array output path.
// Holds the default lane geometry, the per-lane skew step and a row type,
// plus the helper that turns a lane index into its realignment delay.
package qr_pkg;

  localparam int DATA_W            = 20;
  localparam int CORDIC_PIPE_STAGE = 8;
  localparam int NUM_LANES         = 4;
  localparam int SKEW_D            = CORDIC_PIPE_STAGE + 1;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef sample_t                  row_t [NUM_LANES];

  // The last lane is the most delayed by the array, so it passes straight
  // through; every earlier lane waits for it, one skew step per lane gap.
  function automatic int lane_len(input int lane, input int lanes, input int step);
    return (lanes - 1 - lane) * step;
  endfunction

endpackage

// File: rtl/lane_delay.sv
// Fixed-length {valid,data} shift register used to realign one array lane.
// Ports: clk/reset (sync, active-high), valid/data in, delayed_valid/delayed_data out.
// Latency LEN cycles (LEN=0 is a plain wire); no backpressure, always shifts.
module lane_delay #(
  parameter int LEN = 0,
  parameter int W   = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic [W-1:0] data,
  output logic         delayed_valid,
  output logic [W-1:0] delayed_data
);

  generate
    if (LEN == 0) begin : g_wire
      assign delayed_valid = valid;
      assign delayed_data  = data;
      // A zero-length lane has no state, so the clock and reset go nowhere.
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;
    end else begin : g_sr
      logic [W:0] sr [LEN];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < LEN; i++) sr[i] <= '0;
        end else begin
          sr[0] <= {valid, data};
          for (int i = 1; i < LEN; i++) sr[i] <= sr[i-1];
        end
      end

      assign {delayed_valid, delayed_data} = sr[LEN-1];
    end
  endgenerate

endmodule

// File: rtl/qr_out_deskew.sv
// Realigns the four staggered CORDIC array result lanes into row words and
// queues them in a small FIFO for a valid/ready consumer, tagging frame ends.
// Ports: Clk/Reset (sync, active-high); InValid[3:0]/InData1..4 skewed lanes;
//   OutValid/OutReady handshake with OutData1..4/OutLast at the FIFO head;
//   SkewErr pulses on a partial aligned row, Overflow is sticky on a drop.
// Latency: lane-3 sample at t shows on OutData at t+2 into an empty FIFO.
// Backpressure: rows queue while OutReady=0; a push into a full FIFO with
//   no simultaneous pop is dropped and sets Overflow.
module qr_out_deskew #(
  parameter int CORDIC_PIPE_STAGE = qr_pkg::CORDIC_PIPE_STAGE,
  parameter int DATA_W            = qr_pkg::DATA_W,
  parameter int NUM_LANES         = qr_pkg::NUM_LANES,
  parameter int ROWS              = 4,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [3:0]        InValid,
  input  logic [DATA_W-1:0] InData1,
  input  logic [DATA_W-1:0] InData2,
  input  logic [DATA_W-1:0] InData3,
  input  logic [DATA_W-1:0] InData4,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData1,
  output logic [DATA_W-1:0] OutData2,
  output logic [DATA_W-1:0] OutData3,
  output logic [DATA_W-1:0] OutData4,
  output logic              OutLast,
  output logic              SkewErr,
  output logic              Overflow
);

  import qr_pkg::lane_len;

  localparam int D    = CORDIC_PIPE_STAGE + 1;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ROWW = NUM_LANES * DATA_W;

  // ---------------- per-lane deskew ----------------
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_data;
  logic [NUM_LANES-1:0][DATA_W-1:0] dly_data;
  logic [NUM_LANES-1:0]             dly_valid;

  assign lane_data = {InData4, InData3, InData2, InData1};

  generate
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      lane_delay #(
        .LEN (lane_len(k, NUM_LANES, D)),
        .W   (DATA_W)
      ) u_lane (
        .clk           (Clk),
        .reset         (Reset),
        .valid         (InValid[k]),
        .data          (lane_data[k]),
        .delayed_valid (dly_valid[k]),
        .delayed_data  (dly_data[k])
      );
    end
  endgenerate

  // ---------------- align stage ----------------
  logic            all_valid;
  logic            any_valid;
  logic            cand_valid;
  logic [ROWW-1:0] cand_row;
  logic            skew_err;

  assign all_valid = &dly_valid;
  assign any_valid = |dly_valid;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cand_valid <= 1'b0;
      cand_row   <= '0;
      skew_err   <= 1'b0;
    end else begin
      cand_valid <= all_valid;
      // A partial row is reported and discarded rather than pushed.
      skew_err   <= any_valid & ~all_valid;
      if (all_valid) cand_row <= dly_data;
    end
  end

  // ---------------- row FIFO ----------------
  logic [ROWW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [RW-1:0]   row_cnt;
  logic            overflow;
  logic            full;
  logic            not_empty;
  logic            push;
  logic            pop;
  logic            drop;
  logic [ROWW-1:0] head;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign not_empty = (count != '0);
  assign pop       = not_empty & OutReady;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = cand_valid & (~full | pop);
  assign drop      = cand_valid & full & ~pop;

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= cand_row;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      row_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) row_cnt <= (row_cnt == RW'(ROWS - 1)) ? '0 : row_cnt + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // Memory is not reset, so the head is masked until it holds a real row.
  assign head     = not_empty ? mem[rd_ptr] : '0;
  assign OutValid = not_empty;
  assign OutData1 = head[0*DATA_W +: DATA_W];
  assign OutData2 = head[1*DATA_W +: DATA_W];
  assign OutData3 = head[2*DATA_W +: DATA_W];
  assign OutData4 = head[3*DATA_W +: DATA_W];
  assign OutLast  = not_empty && (row_cnt == RW'(ROWS - 1));
  assign SkewErr  = skew_err;
  assign Overflow = overflow;

endmodule

// File: tb/tb_qr_out_deskew.sv
module tb_qr_out_deskew;

  localparam int NC = 1024;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  InValid = '0;
  logic [19:0] InData1 = '0, InData2 = '0, InData3 = '0, InData4 = '0;
  logic        OutValid, OutReady = 1'b1, OutLast, SkewErr, Overflow;
  logic [19:0] OutData1, OutData2, OutData3, OutData4;

  qr_out_deskew dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid),
    .InData1(InData1), .InData2(InData2), .InData3(InData3), .InData4(InData4),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutData1(OutData1), .OutData2(OutData2), .OutData3(OutData3), .OutData4(OutData4),
    .OutLast(OutLast), .SkewErr(SkewErr), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Per-cycle input schedule (lane valids and lane data).
  logic [3:0]  tv [NC];
  logic [19:0] td [4][NC];

  // Observations.
  int          pop_cyc [$];
  logic [79:0] pop_dat [$];
  logic        pop_last[$];
  int          serr_cyc[$];

  function automatic logic [79:0] mk(input logic [19:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [79:0] outrow();
    return {OutData4, OutData3, OutData2, OutData1};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Lane k of a row enters 9*k cycles after lane 0 (D = 9).
  task automatic sched(input int start, input logic [79:0] row, input logic [3:0] mask);
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) tv[start + 9*k][k] = 1'b1;
      td[k][start + 9*k] = row[k*20 +: 20];
    end
  endtask

  task automatic tick();
    InValid = tv[cyc];
    InData1 = td[0][cyc];
    InData2 = td[1][cyc];
    InData3 = td[2][cyc];
    InData4 = td[3][cyc];
    if (OutValid === 1'b1 && OutReady === 1'b1) begin
      pop_cyc.push_back(cyc);
      pop_dat.push_back(outrow());
      pop_last.push_back(OutLast);
    end
    if (SkewErr === 1'b1) serr_cyc.push_back(cyc);
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_obs();
    pop_cyc.delete(); pop_dat.delete(); pop_last.delete(); serr_cyc.delete();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    clear_obs();
  endtask

  function automatic int pcyc(input int i);
    return (i < pop_cyc.size()) ? pop_cyc[i] : -1;
  endfunction
  function automatic logic [79:0] pdat(input int i);
    return (i < pop_dat.size()) ? pop_dat[i] : 'x;
  endfunction
  function automatic logic plast(input int i);
    return (i < pop_last.size()) ? pop_last[i] : 1'bx;
  endfunction

  int b;
  logic [79:0] exp_row;
  logic [79:0] rows5 [11];

  initial begin
    for (int c = 0; c < NC; c++) begin
      tv[c] = '0;
      for (int k = 0; k < 4; k++) td[k][c] = '0;
    end
    @(posedge Clk);
    #1;

    // ---- Reset then idle ----
    Reset = 1'b1;
    tick(); tick(); tick();
    Reset = 1'b0;
    clear_obs();
    chk("rst_outvalid", {79'd0, OutValid}, 80'd0);
    chk("rst_outdata",  outrow(), 80'd0);
    chk("rst_flags",    {77'd0, OutLast, SkewErr, Overflow}, 80'd0);
    b = cyc;
    run_to(b + 50);
    chk("idle_pops", 80'(pop_cyc.size()), 80'd0);
    chk("idle_serr", 80'(serr_cyc.size()), 80'd0);
    chk("idle_state", {77'd0, OutValid, SkewErr, Overflow}, 80'd0);
    chk("idle_outdata", outrow(), 80'd0);

    // ---- Single row: latency check ----
    do_reset();
    b = cyc;
    sched(b + 10, mk(20'd100, 20'd101, 20'd102, 20'd103), 4'b1111);
    run_to(b + 60);
    chk("single_npop", 80'(pop_cyc.size()), 80'd1);
    chk("single_cyc",  80'(pcyc(0) - b), 80'd39);
    chk("single_dat",  pdat(0), mk(20'd100, 20'd101, 20'd102, 20'd103));
    chk("single_last", {79'd0, plast(0)}, 80'd0);

    // ---- Frame of 4 rows plus next frame's row 0 ----
    do_reset();
    b = cyc;
    for (int r = 0; r < 5; r++)
      sched(b + 5 + r, mk(20'(r*16), 20'(r*16+1), 20'(r*16+2), 20'(r*16+3)), 4'b1111);
    run_to(b + 50);
    chk("frame_npop", 80'(pop_cyc.size()), 80'd5);
    for (int r = 0; r < 5; r++) begin
      chk($sformatf("frame_cyc%0d", r), 80'(pcyc(r) - b), 80'(34 + r));
      chk($sformatf("frame_dat%0d", r), pdat(r),
          mk(20'(r*16), 20'(r*16+1), 20'(r*16+2), 20'(r*16+3)));
      chk($sformatf("frame_last%0d", r), {79'd0, plast(r)}, {79'd0, r == 3});
    end

    // ---- Skew error: lane 2 of row 1 missing ----
    do_reset();
    b = cyc;
    for (int r = 0; r < 6; r++)
      sched(b + 5 + r, mk(20'(r*16+8), 20'(r*16+9), 20'(r*16+10), 20'(r*16+11)),
            (r == 1) ? 4'b1011 : 4'b1111);
    run_to(b + 55);
    chk("skew_nserr", 80'(serr_cyc.size()), 80'd1);
    chk("skew_serr_cyc", 80'((serr_cyc.size() > 0 ? serr_cyc[0] : -1) - b), 80'd34);
    chk("skew_npop", 80'(pop_cyc.size()), 80'd5);
    begin
      int idx = 0;
      for (int r = 0; r < 6; r++) begin
        if (r != 1) begin
          chk($sformatf("skew_dat%0d", r), pdat(idx),
              mk(20'(r*16+8), 20'(r*16+9), 20'(r*16+10), 20'(r*16+11)));
          chk($sformatf("skew_cyc%0d", r), 80'(pcyc(idx) - b), 80'(34 + r));
          // Counter skips the dropped row: the 4th delivered row closes the frame.
          chk($sformatf("skew_last%0d", r), {79'd0, plast(idx)}, {79'd0, idx == 3});
          idx++;
        end
      end
    end

    // ---- Backpressure and overflow ----
    do_reset();
    b = cyc;
    OutReady = 1'b0;
    for (int r = 0; r < 10; r++) begin
      rows5[r] = mk(20'(256 + r*16), 20'(257 + r*16), 20'(258 + r*16), 20'hF0000 | 20'(r));
      sched(b + 5 + r, rows5[r], 4'b1111);
    end
    // This row's push coincides with the first pop while the FIFO is full.
    rows5[10] = mk(20'hAAAAA, 20'h55555, 20'h80000, 20'h7FFFF);
    sched(b + 32, rows5[10], 4'b1111);
    run_to(b + 41);
    chk("ovf_before", {78'd0, OutValid, Overflow}, 80'b10);
    run_to(b + 42);
    chk("ovf_after", {79'd0, Overflow}, 80'd1);
    run_to(b + 45);
    chk("ovf_hold_dat", outrow(), rows5[0]);
    chk("ovf_hold_last", {79'd0, OutLast}, 80'd0);
    run_to(b + 60);
    chk("ovf_hold_dat2", outrow(), rows5[0]);
    OutReady = 1'b1;
    run_to(b + 80);
    chk("drain_npop", 80'(pop_cyc.size()), 80'd9);
    for (int i = 0; i < 9; i++) begin
      exp_row = (i < 8) ? rows5[i] : rows5[10];
      chk($sformatf("drain_dat%0d", i), pdat(i), exp_row);
      chk($sformatf("drain_cyc%0d", i), 80'(pcyc(i) - b), 80'(60 + i));
      chk($sformatf("drain_last%0d", i), {79'd0, plast(i)}, {79'd0, i == 3 || i == 7});
    end
    chk("drain_sticky", {79'd0, Overflow}, 80'd1);

    // ---- Reset mid-frame with rows buffered and a partial row in flight ----
    clear_obs();
    b = cyc;
    OutReady = 1'b0;
    for (int r = 0; r < 3; r++)
      sched(b + 5 + r, mk(20'(r+1), 20'(r+2), 20'(r+3), 20'(r+4)), 4'b1111);
    sched(b + 20, mk(20'hDEAD0, 20'hBEEF1, 20'd0, 20'd0), 4'b0011);
    run_to(b + 40);
    chk("pre_rst", {78'd0, OutValid, Overflow}, 80'b11);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    clear_obs();
    chk("post_rst_flags", {77'd0, OutValid, Overflow, OutLast}, 80'd0);
    chk("post_rst_dat", outrow(), 80'd0);
    OutReady = 1'b1;
    for (int r = 0; r < 4; r++)
      sched(b + 45 + r, mk(20'h80000 | 20'(r*4), 20'h80000 | 20'(r*4+1),
                           20'h80000 | 20'(r*4+2), 20'h80000 | 20'(r*4+3)), 4'b1111);
    run_to(b + 95);
    chk("fresh_npop", 80'(pop_cyc.size()), 80'd4);
    chk("fresh_serr", 80'(serr_cyc.size()), 80'd0);
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("fresh_dat%0d", r), pdat(r),
          mk(20'h80000 | 20'(r*4), 20'h80000 | 20'(r*4+1),
             20'h80000 | 20'(r*4+2), 20'h80000 | 20'(r*4+3)));
      chk($sformatf("fresh_cyc%0d", r), 80'(pcyc(r) - b), 80'(74 + r));
      chk($sformatf("fresh_last%0d", r), {79'd0, plast(r)}, {79'd0, r == 3});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qr_out_deskew.md
Name: qr_out_deskew

Overview:
- Output-side counterpart of the column skew applied ahead of the QR systolic array.
- The CORDIC array emits its 4 result lanes staggered: lane k lags lane 0 by k*D cycles, with D = CORDIC_PIPE_STAGE+1.
- This block delays each lane to realign all four into row words, buffers them in a small FIFO, and hands rows downstream over a valid/ready handshake.
- Each row is tagged with its position in a ROWS-row matrix frame.

Parameters:
- CORDIC_PIPE_STAGE, 8, CORDIC pipeline depth; sets per-lane skew D = CORDIC_PIPE_STAGE+1.
- DATA_W, 20, signed width of each lane sample.
- NUM_LANES, 4, number of array output columns (fixed at 4 for this revision).
- ROWS, 4, rows per matrix frame.
- FIFO_DEPTH, 8, aligned-row buffer entries (power of 2).

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  4  per-lane valid; bit k qualifies InData(k+1).
- InData1..InData4  in  DATA_W each  signed lane samples, skewed as produced by the array.
- OutValid  out  1  FIFO head holds a row.
- OutReady  in  1  downstream accepts; a pop occurs when OutValid && OutReady.
- OutData1..OutData4  out  DATA_W each  aligned row (FIFO head, first-word fall-through).
- OutLast  out  1  head row is row ROWS-1 of its frame.
- SkewErr  out  1  one-cycle pulse: aligned valids disagree.
- Overflow  out  1  sticky: a row was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, active-high):
  - Clears delay lines (data and valid), the align register, FIFO pointers and count, and the row counter.
  - OutValid=0, OutData*=0, OutLast=0, SkewErr=0, Overflow=0.
  - Asserting Reset mid-frame discards all in-flight and buffered rows; the next row after reset is row 0.
- Deskew:
  - Lane k (k=0..3) passes through a shift register of length L_k=(3-k)*D carrying {valid,data}.
  - Lane 3 has length 0 (direct).
  - With the default parameters, L = 27, 18, 9, 0.
- Align stage (registered, 1 cycle):
  - av = AND of the four delayed valids; ov = OR of them.
  - If av: latch the row as a push candidate.
  - If ov && !av: pulse SkewErr the next cycle, push nothing, and do not touch the row counter.
- FIFO push and pop:
  - Push happens the cycle after the align stage.
  - Push when full: drop the row unless a pop occurs in the same cycle; on a drop, set Overflow (sticky until Reset).
  - Push and pop in the same cycle: always allowed. Count is unchanged; both pointers advance and wrap modulo FIFO_DEPTH.
  - Pop when empty: impossible, because OutValid=0.
- Latency: a lane-3 sample in cycle t, together with its lane-0 partner from cycle t-3D, appears on OutData in cycle t+2 when the FIFO is empty.
- Output stability: OutData*/OutLast are held stable while OutValid && !OutReady.
- Row counter:
  - 0..ROWS-1; increments on each pop and wraps to 0 after ROWS-1.
  - OutLast = OutValid && (count==ROWS-1).
- Arithmetic: data is passed bit-exact, with no sign extension or saturation.
- Throughput: 1 row per cycle sustained when OutReady=1.

Decomposition:
- Shared package (qr_pkg):
  - DATA_W, CORDIC_PIPE_STAGE, NUM_LANES.
  - Derived constant SKEW_D = CORDIC_PIPE_STAGE+1.
  - A row type: array of NUM_LANES signed DATA_W samples.
- One natural sub-module: lane_delay (parameterised length, {valid,data} shift register; length 0 degenerates to a wire), instantiated 4 times.
- FIFO and row counter stay inline.

Test Plan:
- Reset then idle, InValid=0 for 50 cycles -> OutValid=0, SkewErr=0, Overflow=0, OutData*=0.
- Single row: lane k driven with value 100+k valid in cycle 10+9k (D=9), OutReady=1 -> OutValid one cycle at cycle 39, OutData=100,101,102,103, OutLast=0.
- Frame of 4 rows fed back-to-back with correct skew (values r*16+k), OutReady=1 -> four consecutive OutValid cycles with matching data; OutLast=1 only on row 3; the next frame's row 0 has OutLast=0.
- Lane 2 valid dropped for one row -> SkewErr pulses exactly once, that row is absent, the surrounding rows are intact, and the row counter is not advanced.
- OutReady=0 while 10 skewed rows arrive -> the first 8 are buffered and Overflow=1 after the 9th. Raising OutReady drains rows 0..7 in order; the simultaneous push/pop at full drops nothing.
- Reset asserted for 1 cycle mid-frame with 3 rows buffered -> OutValid=0 next cycle and Overflow cleared. A fresh row emerges with OutLast=0 as row 0; no stale lane data appears.
